// File: rtl/tick_sequencer.sv
// Programmable tick-enable generator with an IDLE/RUN/PAUSE/DONE run controller.
// Optional TICK_CLK_OUT_EN adds clk_div, a square wave toggling on every tick.
module tick_sequencer #(
   parameter int WIDTH          = 32,
   parameter int DEFAULT_CYCLES = 50000000,
   parameter int BURST_W        = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [WIDTH-1:0]   cfg_cycles,
   input  logic [BURST_W-1:0] cfg_burst,
   output logic               tick,
   output logic               busy,
   output logic               done,
   output logic [1:0]         state,
   output logic [BURST_W-1:0] tick_count
`ifdef TICK_CLK_OUT_EN
   ,
   output logic               clk_div
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // A zero period would never produce a tick, so the reset value is clamped like cfg_cycles.
   localparam int DEFAULT_PERIOD = (DEFAULT_CYCLES < 1) ? 1 : DEFAULT_CYCLES;

   logic [1:0]         state_reg, state_next;
   logic [WIDTH-1:0]   period_reg, period_next;
   logic [BURST_W-1:0] burst_reg, burst_next;
   logic [WIDTH-1:0]   cnt_reg, cnt_next;
   logic [BURST_W-1:0] tick_count_reg, tick_count_next;
   logic               tick_reg, tick_next;
   logic               done_reg, done_next;
   logic               cfg_fire;
   logic               period_end;

   assign cfg_ready  = (state_reg == IDLE);
   assign busy       = (state_reg == RUN) || (state_reg == PAUSE);
   assign cfg_fire   = cfg_valid && cfg_ready;
   assign period_end = (cnt_reg == period_reg - WIDTH'(1));

   always_comb begin
      state_next      = state_reg;
      period_next     = period_reg;
      burst_next      = burst_reg;
      cnt_next        = cnt_reg;
      tick_count_next = tick_count_reg;
      tick_next       = 1'b0;
      done_next       = 1'b0;

      if (cfg_fire) begin
         period_next = (cfg_cycles == '0) ? WIDTH'(1) : cfg_cycles;
         burst_next  = cfg_burst;
      end

      case (state_reg)
         IDLE: begin
            // stop and pause outrank start, even while idle.
            if (start && !stop && !pause) begin
               state_next      = RUN;
               cnt_next        = '0;
               tick_count_next = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (pause) begin
               state_next = PAUSE;
            end else if (period_end) begin
               cnt_next        = '0;
               tick_next       = 1'b1;
               tick_count_next = tick_count_reg + BURST_W'(1);
               if ((burst_reg != '0) && (tick_count_next == burst_reg)) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + WIDTH'(1);
            end
         end
         PAUSE: begin
            // Counter is held on the resume edge too, so the period is neither restarted nor shortened.
            if (stop) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (!pause) begin
               state_next = RUN;
            end
         end
         DONE: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         period_reg     <= WIDTH'(DEFAULT_PERIOD);
         burst_reg      <= '0;
         cnt_reg        <= '0;
         tick_count_reg <= '0;
         tick_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         period_reg     <= period_next;
         burst_reg      <= burst_next;
         cnt_reg        <= cnt_next;
         tick_count_reg <= tick_count_next;
         tick_reg       <= tick_next;
         done_reg       <= done_next;
      end
   end

   assign tick       = tick_reg;
   assign done       = done_reg;
   assign state      = state_reg;
   assign tick_count = tick_count_reg;

`ifdef TICK_CLK_OUT_EN
   logic clk_div_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_div_reg <= 1'b0;
      end else if (tick_next) begin
         clk_div_reg <= ~clk_div_reg;
      end
   end

   assign clk_div = clk_div_reg;
`endif

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer with DEFAULT_CYCLES=4, BURST_W=4.
// Define TICK_CLK_OUT_EN to also exercise clk_div.
module tb_tick_sequencer;

   localparam int WIDTH   = 32;
   localparam int BURST_W = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               start, stop, pause, cfg_valid;
   logic               cfg_ready;
   logic [WIDTH-1:0]   cfg_cycles;
   logic [BURST_W-1:0] cfg_burst;
   logic               tick, busy, done;
   logic [1:0]         state;
   logic [BURST_W-1:0] tick_count;
`ifdef TICK_CLK_OUT_EN
   logic               clk_div;
`endif

   int checks = 0;
   int errors = 0;

   tick_sequencer #(
      .WIDTH(WIDTH),
      .DEFAULT_CYCLES(4),
      .BURST_W(BURST_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .stop(stop),
      .pause(pause),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_cycles(cfg_cycles),
      .cfg_burst(cfg_burst),
      .tick(tick),
      .busy(busy),
      .done(done),
      .state(state),
      .tick_count(tick_count)
`ifdef TICK_CLK_OUT_EN
      ,
      .clk_div(clk_div)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end else begin
         $display("ok   %s: %0h", tag, actual);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
      cfg_valid = 1'b0; cfg_cycles = '0; cfg_burst = '0;
      step(); step();
      rst = 1'b0;
      step();

      check("reset_state", 32'(state), 32'd0);
      check("reset_tick", 32'(tick), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_tick_count", 32'(tick_count), 32'd0);
      check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
`ifdef TICK_CLK_OUT_EN
      check("reset_clk_div", 32'(clk_div), 32'd0);
`endif

      // 1: continuous run at the default period of 4
      start = 1'b1;
      step();
      start = 1'b0;
      check("t1_state_run", 32'(state), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      for (int k = 1; k <= 12; k++) begin
         step();
         check($sformatf("t1_tick_c%0d", k), 32'(tick), 32'((k % 4) == 0));
         if ((k % 4) == 0)
            check($sformatf("t1_count_c%0d", k), 32'(tick_count), 32'(k / 4));
`ifdef TICK_CLK_OUT_EN
         check($sformatf("t1_clk_div_c%0d", k), 32'(clk_div), 32'((k / 4) % 2));
`endif
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("t1_stop_state", 32'(state), 32'd0);
      check("t1_stop_tick", 32'(tick), 32'd0);
      check("t1_stop_count_held", 32'(tick_count), 32'd3);

      // 2: burst of 2 at period 3
      cfg_valid = 1'b1; cfg_cycles = 32'd3; cfg_burst = 4'd2;
      step();
      cfg_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("t2_tick_c%0d", k), 32'(tick), 32'((k % 3) == 0));
         check($sformatf("t2_done_c%0d", k), 32'(done), 32'(k == 6));
      end
      check("t2_state_done", 32'(state), 32'd3);
      check("t2_count", 32'(tick_count), 32'd2);
      step();
      check("t2_state_idle", 32'(state), 32'd0);
      check("t2_done_cleared", 32'(done), 32'd0);
      check("t2_tick_cleared", 32'(tick), 32'd0);

      // 3: pause mid-period holds the count
      cfg_valid = 1'b1; cfg_cycles = 32'd4; cfg_burst = 4'd0;
      step();
      cfg_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      pause = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("t3_pause_state_%0d", k), 32'(state), 32'd2);
         check($sformatf("t3_pause_tick_%0d", k), 32'(tick), 32'd0);
      end
      check("t3_pause_busy", 32'(busy), 32'd1);
      pause = 1'b0;
      step();
      check("t3_resume_state", 32'(state), 32'd1);
      check("t3_resume_tick0", 32'(tick), 32'd0);
      step();
      check("t3_resume_tick1", 32'(tick), 32'd0);
      step();
      check("t3_resume_tick2", 32'(tick), 32'd1);
      check("t3_count", 32'(tick_count), 32'd1);

      // 4: stop together with pause wins
      stop = 1'b1; pause = 1'b1;
      step();
      stop = 1'b0; pause = 1'b0;
      check("t4_state", 32'(state), 32'd0);
      check("t4_tick", 32'(tick), 32'd0);
      check("t4_cfg_ready", 32'(cfg_ready), 32'd1);
      check("t4_busy", 32'(busy), 32'd0);

      // 5: config offered while running is refused
      start = 1'b1;
      step();
      start = 1'b0;
      cfg_valid = 1'b1; cfg_cycles = 32'd2; cfg_burst = 4'd1;
      #1;
      check("t5_cfg_ready_run", 32'(cfg_ready), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("t5_tick_c%0d", k), 32'(tick), 32'(k == 4));
         check($sformatf("t5_state_c%0d", k), 32'(state), 32'd1);
      end
      cfg_valid = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;

      // 5b: cfg_cycles=0 with start in the same cycle -> tick every cycle
      cfg_valid = 1'b1; cfg_cycles = 32'd0; cfg_burst = 4'd0; start = 1'b1;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("t5b_tick_c%0d", k), 32'(tick), 32'd1);
         check($sformatf("t5b_count_c%0d", k), 32'(tick_count), 32'(k));
      end

      // 6: asynchronous reset mid-run
      rst = 1'b1;
      #1;
      check("t6_rst_state", 32'(state), 32'd0);
      check("t6_rst_tick", 32'(tick), 32'd0);
      check("t6_rst_count", 32'(tick_count), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
`ifdef TICK_CLK_OUT_EN
      check("t6_rst_clk_div", 32'(clk_div), 32'd0);
`endif
      #2;
      rst = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         check($sformatf("t6_default_tick_c%0d", k), 32'(tick), 32'(k == 4));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
